mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//   MIPS memory-access stage. Consumes the registered EX/MEM outputs and performs
//   loads/stores on the data bus with a req/ack handshake. While a transfer is
//   in flight it asserts stallreq to ctrl. It produces write-back data for the
//   MEM/WB register.
// PARAMETERS
//   none (aluop encodings fixed: LB E0, LH E1, LW E3, LBU E4, LHU E5, SB E8, SH E9, SW EB, LL F0, SC F8 hex)
// PORTS
//   clk        in   1   clock
//   rst        in   1   reset, synchronous, active-high
//   stall      in   6   ctrl stall vector; stall[3]=1 holds EX/MEM contents
//   mem_wd     in   5   dest register         | mem_wdata  in 32  ALU result
//   mem_wreg   in   1   reg write enable      | mem_whilo  in  1  hi/lo write enable
//   mem_hi/lo  in  32   hi/lo values          | mem_aluop  in  8  operation
//   mem_mem_addr in 32  effective address     | mem_reg2   in 32  store data
//   wb_wd      out  5   dest register to MEM/WB
//   wb_wdata   out 32   write-back data (load result / ALU result / SC flag)
//   wb_wreg    out  1   | wb_whilo out 1 | wb_hi, wb_lo out 32 (pass-through)
//   stallreq   out  1   request pipeline stall to ctrl
//   bus_req    out  1   data bus request (registered)
//   bus_we     out  1   1=write (registered)
//   bus_addr   out 32   word address {addr[31:2],2'b00} (registered)
//   bus_sel    out  4   byte enables, big-endian (registered)
//   bus_wdata  out 32   store data replicated into lanes (registered)
//   bus_rdata  in  32   read data, valid with bus_ack
//   bus_ack    in   1   one-cycle transfer-complete pulse
// BEHAVIOUR
//   FSM states: IDLE, WAIT, DONE. Reset: state=IDLE, all bus_* = 0, rdata_q=0, llbit=0.
//   rst=1 forces wb_*=0 and stallreq=0 combinationally.
//   IDLE: non-memory aluop -> wb_* = mem_* pass-through, stallreq=0.
//     Memory aluop -> stallreq=1. Load bus_* regs, next=WAIT.
//   WAIT: bus_req=1, stallreq=1. bus_* hold stable until bus_ack.
//     On bus_ack: capture rdata_q, clear bus_req/bus_we/bus_sel next edge, next=DONE.
//   DONE: stallreq=0. wb_wdata = extended rdata_q for loads, mem_wdata for stores.
//     stall[3]=0 -> IDLE; else stay in DONE (no second bus access).
//   Minimum latency per memory op is 3 cycles (IDLE, WAIT with same-cycle ack, DONE).
//   Byte lanes are big-endian: addr[1:0]=00 -> sel 1000, data[31:24].
//     Half: addr[1]=0 -> sel 1100, [31:16]; addr[1]=1 -> sel 0011, [15:0].
//     Word: sel 1111.
//   Stores replicate data: SB {4{b}}, SH {2{h}}, SW reg2.
//   Loads: LB/LH sign-extend; LBU/LHU zero-extend; LW uses the full word.
//   Misaligned LH/LW addresses: low bits are ignored (no exception in this stage).
//   wb_wreg/wb_wd pass through unchanged for all ops, including while stalled.
//   Reset mid-transfer: the FSM returns to IDLE and bus_req drops at that edge.
//     The bus must tolerate the abandoned request.
//   bus_ack outside WAIT is ignored.
// CONFIGURATION
//   LLSC_EN defined: 1-bit llbit register (reset 0), exported as output llbit_o.
//     LL: behaves as LW; llbit<=1 on the DONE->IDLE transition.
//     SC with llbit=1: SW transfer, wb_wdata=1, llbit<=0 on DONE->IDLE.
//     SC with llbit=0: no bus access, stallreq=0, wb_wdata=0 in IDLE (single cycle).
//   LLSC_EN undefined: F0/F8 are non-memory ops (pass-through), no llbit_o port.
// TESTING
//   1. SW addr=0x100, reg2=0xDEADBEEF, ack 2 cycles after req
//      -> bus_we=1, sel=1111, addr=0x100; stallreq high 3 cycles, then 0 for 1 cycle.
//   2. LB addr=0x203, bus_rdata=0x112233F0 -> sel=0001, wb_wdata=0xFFFFFFF0.
//      LBU at the same address -> 0x000000F0.
//   3. LH addr=0x202, rdata=0x12348001 -> sel=0011, wb_wdata=0xFFFF8001.
//      LHU -> 0x00008001. SH addr=0x200, reg2=0xABCD -> wdata=0xABCDABCD, sel=1100.
//   4. Non-memory op (aluop 0x20, wdata=5) -> no bus_req, stallreq=0, wb_wdata=5 same cycle.
//   5. rst asserted in WAIT with ack withheld -> next cycle state=IDLE, bus_req=0.
//      A later LW completes normally.
//   6. (LLSC_EN) LL 0x40 then SC 0x40 -> SC writes, wb_wdata=1, llbit=0.
//      A second SC -> no bus_req, wb_wdata=0.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: MIPS memory-access stage.
// Runs loads and stores on a req/ack data bus and holds the pipeline through
// stallreq while a transfer is in flight. It also produces the write-back
// values for the MEM/WB register.
// Optional LL/SC support is built when the LLSC_EN macro is defined. That
// build adds the llbit register and the llbit_o port.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [4:0]  mem_wd,
    input  logic [31:0] mem_wdata,
    input  logic        mem_wreg,
    input  logic        mem_whilo,
    input  logic [31:0] mem_hi,
    input  logic [31:0] mem_lo,
    input  logic [7:0]  mem_aluop,
    input  logic [31:0] mem_mem_addr,
    input  logic [31:0] mem_reg2,
    output logic [4:0]  wb_wd,
    output logic [31:0] wb_wdata,
    output logic        wb_wreg,
    output logic        wb_whilo,
    output logic [31:0] wb_hi,
    output logic [31:0] wb_lo,
    output logic        stallreq,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
`ifdef LLSC_EN
    output logic        llbit_o,
`endif
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam int unsigned DW   = 32;
    localparam int unsigned SELW = 4;
    localparam int unsigned OPW  = 8;

    localparam logic [OPW-1:0] OP_LB  = 8'hE0;
    localparam logic [OPW-1:0] OP_LH  = 8'hE1;
    localparam logic [OPW-1:0] OP_LW  = 8'hE3;
    localparam logic [OPW-1:0] OP_LBU = 8'hE4;
    localparam logic [OPW-1:0] OP_LHU = 8'hE5;
    localparam logic [OPW-1:0] OP_SB  = 8'hE8;
    localparam logic [OPW-1:0] OP_SH  = 8'hE9;
    localparam logic [OPW-1:0] OP_SW  = 8'hEB;
`ifdef LLSC_EN
    localparam logic [OPW-1:0] OP_LL  = 8'hF0;
    localparam logic [OPW-1:0] OP_SC  = 8'hF8;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            is_load;
    logic            is_store;
    logic [SELW-1:0] sel_c;
    logic [DW-1:0]   st_data_c;
    logic [DW-1:0]   load_c;
    logic [DW-1:0]   rdata_q;
    logic            bus_load;
    logic            ack_take;
    logic            done_exit;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic            llbit;

    // Only stall[3] (the EX/MEM hold) matters in this stage.
    logic unused_stall;
    assign unused_stall = ^{stall[5:4], stall[2:0]};

`ifdef LLSC_EN
    assign llbit_o = llbit;
`endif

    // Decode the op class, the big-endian byte enables and the replicated store data.
    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        sel_c     = '0;
        st_data_c = '0;
        case (mem_aluop)
            OP_LB, OP_LBU: begin
                is_load = 1'b1;
                case (mem_mem_addr[1:0])
                    2'b00:   sel_c = 4'b1000;
                    2'b01:   sel_c = 4'b0100;
                    2'b10:   sel_c = 4'b0010;
                    default: sel_c = 4'b0001;
                endcase
            end
            OP_LH, OP_LHU: begin
                is_load = 1'b1;
                sel_c   = mem_mem_addr[1] ? 4'b0011 : 4'b1100;
            end
            OP_LW: begin
                is_load = 1'b1;
                sel_c   = 4'b1111;
            end
            OP_SB: begin
                is_store  = 1'b1;
                st_data_c = {4{mem_reg2[7:0]}};
                case (mem_mem_addr[1:0])
                    2'b00:   sel_c = 4'b1000;
                    2'b01:   sel_c = 4'b0100;
                    2'b10:   sel_c = 4'b0010;
                    default: sel_c = 4'b0001;
                endcase
            end
            OP_SH: begin
                is_store  = 1'b1;
                st_data_c = {2{mem_reg2[15:0]}};
                sel_c     = mem_mem_addr[1] ? 4'b0011 : 4'b1100;
            end
            OP_SW: begin
                is_store  = 1'b1;
                st_data_c = mem_reg2;
                sel_c     = 4'b1111;
            end
`ifdef LLSC_EN
            OP_LL: begin
                is_load = 1'b1;
                sel_c   = 4'b1111;
            end
            OP_SC: begin
                // A failed SC never reaches the bus.
                if (llbit) begin
                    is_store  = 1'b1;
                    st_data_c = mem_reg2;
                    sel_c     = 4'b1111;
                end
            end
`endif
            default: ;
        endcase
    end

    // Pick the addressed lane out of the captured word and extend it.
    always_comb begin
        byte_v = '0;
        half_v = mem_mem_addr[1] ? rdata_q[15:0] : rdata_q[31:16];
        case (mem_mem_addr[1:0])
            2'b00:   byte_v = rdata_q[31:24];
            2'b01:   byte_v = rdata_q[23:16];
            2'b10:   byte_v = rdata_q[15:8];
            default: byte_v = rdata_q[7:0];
        endcase
        case (mem_aluop)
            OP_LB:   load_c = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  load_c = {24'd0, byte_v};
            OP_LH:   load_c = {{16{half_v[15]}}, half_v};
            OP_LHU:  load_c = {16'd0, half_v};
            default: load_c = rdata_q;
        endcase
    end

    // Next-state logic plus the combinational write-back and stall outputs.
    always_comb begin
        state_nxt = state;
        stallreq  = 1'b0;
        bus_load  = 1'b0;
        ack_take  = 1'b0;
        done_exit = 1'b0;
        wb_wd     = mem_wd;
        wb_wreg   = mem_wreg;
        wb_whilo  = mem_whilo;
        wb_hi     = mem_hi;
        wb_lo     = mem_lo;
        wb_wdata  = mem_wdata;
        case (state)
            IDLE: begin
                if (is_load || is_store) begin
                    stallreq  = 1'b1;
                    bus_load  = 1'b1;
                    state_nxt = WAIT;
                end
`ifdef LLSC_EN
                else if (mem_aluop == OP_SC) begin
                    wb_wdata = '0;
                end
`endif
            end
            WAIT: begin
                stallreq = 1'b1;
                if (bus_ack) begin
                    ack_take  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (is_load) begin
                    wb_wdata = load_c;
                end
`ifdef LLSC_EN
                if (mem_aluop == OP_SC) begin
                    wb_wdata = DW'(1);
                end
`endif
                if (!stall[3]) begin
                    done_exit = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            state_nxt = IDLE;
            stallreq  = 1'b0;
            wb_wd     = '0;
            wb_wreg   = 1'b0;
            wb_whilo  = 1'b0;
            wb_hi     = '0;
            wb_lo     = '0;
            wb_wdata  = '0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Bus request registers: loaded when an op starts, cleared when it is acknowledged.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_sel   <= '0;
            bus_wdata <= '0;
        end else if (bus_load) begin
            bus_req   <= 1'b1;
            bus_we    <= is_store;
            bus_addr  <= {mem_mem_addr[31:2], 2'b00};
            bus_sel   <= sel_c;
            bus_wdata <= st_data_c;
        end else if (ack_take) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_sel   <= '0;
        end
    end

    // Capture read data with the acknowledge.
    always_ff @(posedge clk) begin
        if (rst)           rdata_q <= '0;
        else if (ack_take) rdata_q <= bus_rdata;
    end

`ifdef LLSC_EN
    // Link bit: set by a completed LL, cleared by a completed successful SC.
    always_ff @(posedge clk) begin
        if (rst) begin
            llbit <= 1'b0;
        end else if (done_exit) begin
            if (mem_aluop == OP_LL)      llbit <= 1'b1;
            else if (mem_aluop == OP_SC) llbit <= 1'b0;
        end
    end
`else
    assign llbit = 1'b0;
    logic unused_llbit;
    assign unused_llbit = llbit;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven bench for mem_stage with a queue scoreboard.
// Covers LL/SC vectors when LLSC_EN is defined; otherwise it covers F0/F8 pass-through.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata;
    logic        mem_wreg;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr;
    logic [31:0] mem_reg2;
    logic [4:0]  wb_wd;
    logic [31:0] wb_wdata;
    logic        wb_wreg;
    logic        wb_whilo;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        stallreq;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
`ifdef LLSC_EN
    logic        llbit_o;
`endif

    localparam logic [31:0] JUNK = 32'hBAD0BAD0;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [7:0]  aluop;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_lat;
        int          hold;
        logic        exp_req;
        logic        exp_we;
        logic [3:0]  exp_sel;
        logic [31:0] exp_baddr;
        logic [31:0] exp_bwdata;
        logic [31:0] exp_wb;
        int          exp_stalls;
    } vec_t;

    vec_t        vq[$];
    logic [31:0] exp_q[$];

    mem_stage dut (
        .clk(clk), .rst(rst), .stall(stall),
        .mem_wd(mem_wd), .mem_wdata(mem_wdata), .mem_wreg(mem_wreg),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
        .wb_wd(wb_wd), .wb_wdata(wb_wdata), .wb_wreg(wb_wreg),
        .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
        .stallreq(stallreq), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_sel(bus_sel), .bus_wdata(bus_wdata),
`ifdef LLSC_EN
        .llbit_o(llbit_o),
`endif
        .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one EX/MEM op, answer the bus, and score the write-back when stallreq drops.
    task automatic run_op(input vec_t v, input int idx);
        int          stall_cnt = 0;
        int          req_cyc   = 0;
        bit          seen_req  = 1'b0;
        bit          done      = 1'b0;
        logic [31:0] exp;
        mem_aluop    = v.aluop;
        mem_mem_addr = v.addr;
        mem_reg2     = v.reg2;
        mem_wdata    = v.wdata;
        mem_wd       = 5'(idx);
        mem_wreg     = 1'b1;
        mem_whilo    = idx[0];
        mem_hi       = ~v.wdata;
        mem_lo       = v.addr;
        stall        = '0;
        bus_ack      = 1'b0;
        bus_rdata    = JUNK;
        exp_q.push_back(v.exp_wb);
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (bus_req) begin
                if (!seen_req) begin
                    check($sformatf("v%0d bus_we", idx), 32'(bus_we), 32'(v.exp_we));
                    check($sformatf("v%0d bus_sel", idx), 32'(bus_sel), 32'(v.exp_sel));
                    check($sformatf("v%0d bus_addr", idx), bus_addr, v.exp_baddr);
                    if (v.exp_we) check($sformatf("v%0d bus_wdata", idx), bus_wdata, v.exp_bwdata);
                end else begin
                    check($sformatf("v%0d bus_sel_hold", idx), 32'(bus_sel), 32'(v.exp_sel));
                end
                seen_req  = 1'b1;
                req_cyc++;
                bus_ack   = (req_cyc == v.ack_lat);
                bus_rdata = bus_ack ? v.rdata : JUNK;
            end else begin
                bus_ack = 1'b0;
            end
            if (!stallreq) begin
                exp = exp_q.pop_front();
                check($sformatf("v%0d wb_wdata", idx), wb_wdata, exp);
                check($sformatf("v%0d stall_cycles", idx), 32'(stall_cnt), 32'(v.exp_stalls));
                check($sformatf("v%0d req_seen", idx), 32'(seen_req), 32'(v.exp_req));
                check($sformatf("v%0d bus_req_done", idx), 32'(bus_req), 32'd0);
                check($sformatf("v%0d wb_wd", idx), 32'(wb_wd), 32'(idx[4:0]));
                check($sformatf("v%0d wb_hi", idx), wb_hi, ~v.wdata);
                done = 1'b1;
            end else begin
                stall_cnt++;
                @(posedge clk);
                #1;
                bus_ack   = 1'b0;
                bus_rdata = JUNK;
            end
        end
        if (!done) begin
            n_vec++;
            n_miss++;
            $display("FAIL v%0d timeout: stallreq still 1 after 40 cycles, expected completion", idx);
            void'(exp_q.pop_front());
        end
        for (int h = 0; h < v.hold; h++) begin
            stall = 6'b001000;
            @(posedge clk);
            #1;
            @(negedge clk);
            check($sformatf("v%0d hold_bus_req", idx), 32'(bus_req), 32'd0);
            check($sformatf("v%0d hold_stallreq", idx), 32'(stallreq), 32'd0);
            check($sformatf("v%0d hold_wb_wdata", idx), wb_wdata, v.exp_wb);
        end
        stall = '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t lw_after_rst;
        vq.push_back('{8'hEB, 32'h100, 32'hDEADBEEF, 32'h11111111, 32'h0, 2, 0, 1'b1, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 32'h11111111, 3});
        vq.push_back('{8'hE0, 32'h203, 32'h0, 32'h22, 32'h112233F0, 1, 0, 1'b1, 1'b0, 4'h1, 32'h200, 32'h0, 32'hFFFFFFF0, 2});
        vq.push_back('{8'hE4, 32'h203, 32'h0, 32'h22, 32'h112233F0, 1, 0, 1'b1, 1'b0, 4'h1, 32'h200, 32'h0, 32'h000000F0, 2});
        vq.push_back('{8'hE0, 32'h200, 32'h0, 32'h0, 32'h7F000000, 1, 0, 1'b1, 1'b0, 4'h8, 32'h200, 32'h0, 32'h0000007F, 2});
        vq.push_back('{8'hE0, 32'h201, 32'h0, 32'h0, 32'h00800000, 2, 0, 1'b1, 1'b0, 4'h4, 32'h200, 32'h0, 32'hFFFFFF80, 3});
        vq.push_back('{8'hE1, 32'h202, 32'h0, 32'h0, 32'h12348001, 1, 0, 1'b1, 1'b0, 4'h3, 32'h200, 32'h0, 32'hFFFF8001, 2});
        vq.push_back('{8'hE5, 32'h202, 32'h0, 32'h0, 32'h12348001, 1, 2, 1'b1, 1'b0, 4'h3, 32'h200, 32'h0, 32'h00008001, 2});
        vq.push_back('{8'hE1, 32'h201, 32'h0, 32'h0, 32'h7ABC0000, 1, 0, 1'b1, 1'b0, 4'hC, 32'h200, 32'h0, 32'h00007ABC, 2});
        vq.push_back('{8'hE9, 32'h200, 32'h0000ABCD, 32'h33, 32'h0, 1, 0, 1'b1, 1'b1, 4'hC, 32'h200, 32'hABCDABCD, 32'h33, 2});
        vq.push_back('{8'hE9, 32'h202, 32'hFFFF1234, 32'h34, 32'h0, 1, 0, 1'b1, 1'b1, 4'h3, 32'h200, 32'h12341234, 32'h34, 2});
        vq.push_back('{8'hE8, 32'h101, 32'h1234565A, 32'h35, 32'h0, 3, 1, 1'b1, 1'b1, 4'h4, 32'h100, 32'h5A5A5A5A, 32'h35, 4});
        vq.push_back('{8'hE8, 32'h103, 32'h000000A5, 32'h36, 32'h0, 1, 0, 1'b1, 1'b1, 4'h1, 32'h100, 32'hA5A5A5A5, 32'h36, 2});
        vq.push_back('{8'hE3, 32'h305, 32'h0, 32'h0, 32'hCAFEF00D, 3, 0, 1'b1, 1'b0, 4'hF, 32'h304, 32'h0, 32'hCAFEF00D, 4});
        vq.push_back('{8'h20, 32'h0, 32'h0, 32'h5, 32'h0, 0, 0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h5, 0});
`ifndef LLSC_EN
        vq.push_back('{8'hF0, 32'h40, 32'h0, 32'h77, 32'h0, 0, 0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h77, 0});
        vq.push_back('{8'hF8, 32'h40, 32'h9, 32'h78, 32'h0, 0, 0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h78, 0});
`endif
        lw_after_rst = '{8'hE3, 32'h80, 32'h0, 32'h0, 32'h01020304, 1, 0, 1'b1, 1'b0, 4'hF, 32'h80, 32'h0, 32'h01020304, 2};

        // Reset: wb_* forced to zero even with live inputs, bus registers cleared.
        rst = 1'b1; stall = '0; bus_ack = 1'b0; bus_rdata = JUNK;
        mem_aluop = 8'h20; mem_wdata = 32'h55; mem_wreg = 1'b1; mem_wd = 5'd7;
        mem_whilo = 1'b1; mem_hi = 32'h1; mem_lo = 32'h2; mem_mem_addr = 32'h0; mem_reg2 = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst stallreq", 32'(stallreq), 32'd0);
        check("rst wb_wdata", wb_wdata, 32'd0);
        check("rst wb_wreg", 32'(wb_wreg), 32'd0);
        check("rst wb_wd", 32'(wb_wd), 32'd0);
        check("rst wb_hi", wb_hi, 32'd0);
        check("rst bus_req", 32'(bus_req), 32'd0);
        check("rst bus_sel", 32'(bus_sel), 32'd0);
        check("rst bus_addr", bus_addr, 32'd0);
        check("rst bus_we", 32'(bus_we), 32'd0);
`ifdef LLSC_EN
        check("rst llbit", 32'(llbit_o), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vq[i]) run_op(vq[i], i);

        // Reset while waiting on an acknowledge that never comes.
        mem_aluop = 8'hE3; mem_mem_addr = 32'h80; mem_wdata = 32'h0;
        @(negedge clk);
        check("mid-rst idle stallreq", 32'(stallreq), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid-rst bus_req in wait", 32'(bus_req), 32'd1);
        rst = 1'b1;
        #1;
        check("mid-rst stallreq forced", 32'(stallreq), 32'd0);
        check("mid-rst wb_wdata forced", wb_wdata, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_aluop = 8'h20; mem_wdata = 32'h66;
        @(negedge clk);
        check("post-rst bus_req", 32'(bus_req), 32'd0);
        check("post-rst bus_sel", 32'(bus_sel), 32'd0);
        check("post-rst stallreq", 32'(stallreq), 32'd0);
        check("post-rst wb_wdata", wb_wdata, 32'h66);
        @(posedge clk);
        #1;
        run_op(lw_after_rst, 20);

        // Stray acknowledges outside WAIT must not disturb the FSM.
        mem_aluop = 8'h21; mem_wdata = 32'h99; bus_ack = 1'b1; bus_rdata = 32'h0F0F0F0F;
        repeat (2) begin
            @(negedge clk);
            check("stray ack bus_req", 32'(bus_req), 32'd0);
            check("stray ack stallreq", 32'(stallreq), 32'd0);
            @(posedge clk);
            #1;
        end
        bus_ack = 1'b0;
        run_op(vq[1], 21);

`ifdef LLSC_EN
        // LL links, SC succeeds once, a repeat SC fails without touching the bus.
        run_op('{8'hF0, 32'h40, 32'h0, 32'h0, 32'h13579BDF, 1, 0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0, 32'h13579BDF, 2}, 22);
        @(negedge clk);
        check("ll llbit set", 32'(llbit_o), 32'd1);
        @(posedge clk);
        #1;
        run_op('{8'hF8, 32'h40, 32'h0BADF00D, 32'h0, 32'h0, 1, 0, 1'b1, 1'b1, 4'hF, 32'h40, 32'h0BADF00D, 32'h1, 2}, 23);
        @(negedge clk);
        check("sc llbit cleared", 32'(llbit_o), 32'd0);
        @(posedge clk);
        #1;
        run_op('{8'hF8, 32'h40, 32'h0BADF00D, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 0}, 24);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
